// File: rtl/mac_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// mac_tx_sched_pkg
// Shared definitions for the per-port transmit scheduler:
//   - scheduler state encoding
//   - descriptor field geometry (length field position and width)
//   - wire overhead used by the guard-band check
//   - statistics counter widths and indices
//   - fits_before_slot(): guard-band admission test for best-effort frames
// ---------------------------------------------------------------------------
package mac_tx_sched_pkg;

    localparam int LEN_W       = 12;   // frame length field width (bytes)
    localparam int PTR_W       = 16;   // pointer descriptor width
    localparam int SLOT_W      = 16;   // byte-times-to-next-reservation width
    localparam int OVH_BYTES   = 20;   // preamble/SFD (8) + IFG (12)
    localparam int CNT_W       = 16;   // statistics counter width
    localparam int PTR_LEN_MSB = LEN_W - 1;
    localparam int PTR_LEN_LSB = 0;

    // Statistics counter indices
    localparam int CNT_TTE   = 0;
    localparam int CNT_BE    = 1;
    localparam int CNT_DEFER = 2;
    localparam int CNT_ERR   = 3;
    localparam int NUM_CNT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_INFLIGHT = 2'd2
    } state_e;

    // One bit wider than the slot field so len + overhead can never wrap.
    typedef logic [SLOT_W:0] guard_t;

    // A best-effort frame may start only if its full wire time (payload plus
    // preamble and IFG) ends no later than the next reserved TTE slot.
    function automatic logic fits_before_slot(input logic [LEN_W-1:0]  len,
                                              input logic [SLOT_W-1:0] slot);
        guard_t need;
        need = guard_t'(len) + guard_t'(OVH_BYTES);
        return (need <= guard_t'(slot));
    endfunction

endpackage

// File: rtl/mac_tx_sched_if.sv
// ---------------------------------------------------------------------------
// mac_tx_sched_if
// Descriptor handshake between the transmit scheduler and the GMII TX MAC.
//   desc_valid  scheduler -> MAC  descriptor offered
//   desc_tte    scheduler -> MAC  offered descriptor is TTE traffic
//   desc_len    scheduler -> MAC  frame length in bytes
//   desc_ready  MAC -> scheduler  descriptor accepted (transfer on valid&&ready)
//   tx_done     MAC -> scheduler  1-cycle pulse, frame in flight finished (incl. IFG)
// Modports: master = scheduler side, slave = MAC side.
// ---------------------------------------------------------------------------
interface mac_tx_sched_if;
    import mac_tx_sched_pkg::*;

    logic             desc_valid;
    logic             desc_ready;
    logic             desc_tte;
    logic [LEN_W-1:0] desc_len;
    logic             tx_done;

    modport master (
        output desc_valid,
        output desc_tte,
        output desc_len,
        input  desc_ready,
        input  tx_done
    );

    modport slave (
        input  desc_valid,
        input  desc_tte,
        input  desc_len,
        output desc_ready,
        output tx_done
    );

endinterface

// File: rtl/mac_tx_sched_sat_free_counter.sv
// ---------------------------------------------------------------------------
// sat_free_counter
// Free-running W-bit event counter; wraps from all-ones to zero.
//   clk   in   clock
//   srst  in   synchronous active-high reset (clears the count)
//   inc   in   count one event this cycle
//   cnt   out  current count
// ---------------------------------------------------------------------------
module sat_free_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(inc);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mac_tx_sched.sv
// ---------------------------------------------------------------------------
// mac_tx_sched
// Per-port transmit scheduler between the egress pointer FIFOs and the TX MAC.
// TTE pointers have strict priority over best-effort pointers; one frame is in
// flight at a time and scheduling is non-preemptive. A best-effort frame is
// only admitted if it completes before the next reserved TTE slot.
//   clk, rst_sys                   clock, synchronous active-high reset
//   ptr_fifo_empty/din/rd          best-effort pointer FIFO (FWFT) and pop
//   tptr_fifo_empty/din/rd         TTE pointer FIFO (FWFT) and pop
//   tte_slot_bytes                 byte-times to next TTE reservation (FFFF = none)
//   desc_if                        descriptor handshake to the MAC (master side)
//   busy                           a frame is offered or in flight
//   tte_cnt/be_cnt                 frames issued per class (wrapping)
//   defer_cnt                      cycles a best-effort head was guard-blocked
//   err_cnt                        zero-length descriptors dropped
// ---------------------------------------------------------------------------
module mac_tx_sched
    import mac_tx_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_sys,
    input  logic              ptr_fifo_empty,
    input  logic [PTR_W-1:0]  ptr_fifo_din,
    output logic              ptr_fifo_rd,
    input  logic              tptr_fifo_empty,
    input  logic [PTR_W-1:0]  tptr_fifo_din,
    output logic              tptr_fifo_rd,
    input  logic [SLOT_W-1:0] tte_slot_bytes,
    mac_tx_sched_if.master    desc_if,
    output logic              busy,
    output logic [CNT_W-1:0]  tte_cnt,
    output logic [CNT_W-1:0]  be_cnt,
    output logic [CNT_W-1:0]  defer_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    state_e           state_q, state_d;
    logic             desc_tte_q, desc_tte_d;
    logic [LEN_W-1:0] desc_len_q, desc_len_d;
    logic [LEN_W-1:0] be_len, tte_len;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    // Upper descriptor bits carry information this block does not use.
    logic unused_desc_bits;
    assign unused_desc_bits = ^{ptr_fifo_din[PTR_W-1:LEN_W], tptr_fifo_din[PTR_W-1:LEN_W]};

    assign be_len  = ptr_fifo_din[PTR_LEN_MSB:PTR_LEN_LSB];
    assign tte_len = tptr_fifo_din[PTR_LEN_MSB:PTR_LEN_LSB];

    always_comb begin
        state_d      = state_q;
        desc_tte_d   = desc_tte_q;
        desc_len_d   = desc_len_q;
        ptr_fifo_rd  = 1'b0;
        tptr_fifo_rd = 1'b0;
        cnt_inc      = '0;

        // Gating on reset keeps the reset cycle free of pops and counts.
        if (!rst_sys) begin
            case (state_q)
                ST_IDLE: begin
                    if (!tptr_fifo_empty) begin
                        tptr_fifo_rd = 1'b1;
                        if (tte_len == '0) begin
                            cnt_inc[CNT_ERR] = 1'b1;
                        end else begin
                            desc_tte_d = 1'b1;
                            desc_len_d = tte_len;
                            state_d    = ST_OFFER;
                        end
                    end else if (!ptr_fifo_empty) begin
                        // A zero-length head never reaches the wire, so it is
                        // dropped regardless of the guard band.
                        if (be_len == '0) begin
                            ptr_fifo_rd      = 1'b1;
                            cnt_inc[CNT_ERR] = 1'b1;
                        end else if (fits_before_slot(be_len, tte_slot_bytes)) begin
                            ptr_fifo_rd = 1'b1;
                            desc_tte_d  = 1'b0;
                            desc_len_d  = be_len;
                            state_d     = ST_OFFER;
                        end else begin
                            cnt_inc[CNT_DEFER] = 1'b1;
                        end
                    end
                end
                ST_OFFER: begin
                    if (desc_if.desc_ready) begin
                        if (desc_tte_q) begin
                            cnt_inc[CNT_TTE] = 1'b1;
                        end else begin
                            cnt_inc[CNT_BE] = 1'b1;
                        end
                        state_d = ST_INFLIGHT;
                    end
                end
                ST_INFLIGHT: begin
                    if (desc_if.tx_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state_q    <= ST_IDLE;
            desc_tte_q <= 1'b0;
            desc_len_q <= '0;
        end else begin
            state_q    <= state_d;
            desc_tte_q <= desc_tte_d;
            desc_len_q <= desc_len_d;
        end
    end

    assign desc_if.desc_valid = (state_q == ST_OFFER);
    assign desc_if.desc_tte   = desc_tte_q;
    assign desc_if.desc_len   = desc_len_q;
    assign busy               = (state_q != ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
            sat_free_counter #(.W(CNT_W)) u_cnt (
                .clk  (clk),
                .srst (rst_sys),
                .inc  (cnt_inc[gi]),
                .cnt  (cnt_val[gi])
            );
        end
    endgenerate

    assign tte_cnt   = cnt_val[CNT_TTE];
    assign be_cnt    = cnt_val[CNT_BE];
    assign defer_cnt = cnt_val[CNT_DEFER];
    assign err_cnt   = cnt_val[CNT_ERR];

endmodule
